// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx_fifo
// Summary  : Buffered 8N1 UART transmitter on an MMIO req/resp command port.
//            Writes push a byte into a circular FIFO in a single cycle; a
//            transmitter FSM drains the FIFO onto uart_tx. Reads return a
//            status word (busy/full/empty/count).
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx_fifo #(
    parameter int FMAX_MHz = 27,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        uart_tx,
    output logic        req_ready,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);

    localparam int c_CLKS_PER_BIT = (FMAX_MHz * 1_000_000) / BAUD;
    localparam int c_AW           = $clog2(DEPTH);
    localparam int c_CNT_W        = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;

    localparam logic [c_AW:0]      c_DEPTH_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [7:0]      mem_q [DEPTH];
    logic [c_AW-1:0] wptr_q;
    logic [c_AW-1:0] rptr_q;
    logic [c_AW:0]   count_q;
    logic [c_AW:0]   count_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_rd;
    logic w_busy;

    // Register-offset and the unused upper write-data bits carry no meaning.
    logic w_unused_bits;
    assign w_unused_bits = ^{req_addr, req_wdata[31:8]};

    // ------------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------------
    tx_state_e          state_q, state_d;
    logic [c_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               w_bit_done;

    // ------------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------------
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] w_status;

    assign w_full  = (count_q == c_DEPTH_CNT);
    assign w_empty = (count_q == '0);
    assign w_busy  = (state_q != S_IDLE) || !w_empty;

    // Writes wait on a full FIFO; reads wait only on the response cycle.
    assign req_ready = req_wen ? !w_full : !resp_valid_q;

    assign w_push = req_valid && req_ready && req_wen;
    assign w_rd   = req_valid && req_ready && !req_wen;

    assign w_status = {16'd0, 8'(count_q), 5'd0, w_empty, w_full, w_busy};

    assign w_bit_done = (clk_cnt_q == c_CNT_LAST);

    assign uart_tx    = tx_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    // Occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (c_AW + 1)'(1);
            2'b01:   count_d = count_q - (c_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards the FIFO contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + c_AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= req_wdata[7:0];
        end
    end

    // Transmitter next-state: line level follows the current state, so the
    // registered uart_tx trails the FSM by one cycle.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        w_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    shift_d   = mem_q[rptr_q];
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (w_bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (w_bit_done) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + c_CNT_W'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (w_bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transmitter state register and registered serial output (idle high).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Status capture: one-cycle valid pulse, data held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= w_rd;
            if (w_rd) begin
                resp_rdata_q <= w_status;
            end
        end
    end

endmodule
`default_nettype wire
